// File: rtl/aska_sched_pkg.sv
// aska_sched_pkg: shared types, default widths and index-width helper
// for the channel scheduler (aska_ch_sched, aska_rr_pick, aska_ch_sched_if).
package aska_sched_pkg;

  localparam int NCH_DEF     = 4;
  localparam int GUARD_W_DEF = 4;
  localparam int HOLD_W_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GUARD
  } state_t;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/aska_ch_sched_if.sv
// aska_ch_sched_if: channel-side bundle (req, done in; grant, sel, busy out).
// master = channel timers, slave = scheduler.
interface aska_ch_sched_if
  import aska_sched_pkg::*;
#(
  parameter int NCH = NCH_DEF
) ();

  localparam int IW = idx_w(NCH);

  logic [NCH-1:0] req;
  logic [NCH-1:0] done;
  logic [NCH-1:0] grant;
  logic [IW-1:0]  sel;
  logic           busy;

  modport master (
    output req,
    output done,
    input  grant,
    input  sel,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output sel,
    output busy
  );

endinterface

// File: rtl/aska_rr_pick.sv
// aska_rr_pick: combinational round-robin pick. Ports: vec (candidates),
// ptr (last winner) -> valid, idx (first set bit at or after ptr+1 mod NCH).
module aska_rr_pick
  import aska_sched_pkg::*;
#(
  parameter  int NCH = NCH_DEF,
  localparam int IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] vec,
  input  logic [IW-1:0]  ptr,
  output logic           valid,
  output logic [IW-1:0]  idx
);

  logic [IW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = IW'((int'(ptr) + i) % NCH);
      if (!valid && vec[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/aska_ch_sched.sv
// aska_ch_sched: round-robin slot scheduler for the shared pulse path.
// Ports: clk, resetn, enable, guard_cycles, max_hold, err_clr, timeout_err,
// timeout_ch, bus (slave: req/done in, grant/sel/busy out).
// Optional ASKA_SCHED_PRIO_EN adds prio_mask for a priority subset.
module aska_ch_sched
  import aska_sched_pkg::*;
#(
  parameter  int NCH     = NCH_DEF,
  parameter  int GUARD_W = GUARD_W_DEF,
  parameter  int HOLD_W  = HOLD_W_DEF,
  localparam int IW      = idx_w(NCH)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
`ifdef ASKA_SCHED_PRIO_EN
  input  logic [NCH-1:0]     prio_mask,
`endif
  input  logic [GUARD_W-1:0] guard_cycles,
  input  logic [HOLD_W-1:0]  max_hold,
  input  logic               err_clr,
  output logic               timeout_err,
  output logic [IW-1:0]      timeout_ch,
  aska_ch_sched_if.slave     bus
);

  state_t             state;
  state_t             state_n;
  logic [IW-1:0]      ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [GUARD_W-1:0] guard_cnt;

  logic               pick_v;
  logic [IW-1:0]      pick_i;
  logic [NCH-1:0]     pick_oh;
  logic               done_s;
  logic               to_hit;
  logic               rel;

`ifdef ASKA_SCHED_PRIO_EN
  logic          pv;
  logic          av;
  logic [IW-1:0] pidx;
  logic [IW-1:0] aidx;

  aska_rr_pick #(.NCH(NCH)) u_prio (
    .vec   (bus.req & prio_mask),
    .ptr   (ptr),
    .valid (pv),
    .idx   (pidx)
  );

  aska_rr_pick #(.NCH(NCH)) u_all (
    .vec   (bus.req),
    .ptr   (ptr),
    .valid (av),
    .idx   (aidx)
  );

  assign pick_v = pv | av;
  assign pick_i = pv ? pidx : aidx;
`else
  aska_rr_pick #(.NCH(NCH)) u_all (
    .vec   (bus.req),
    .ptr   (ptr),
    .valid (pick_v),
    .idx   (pick_i)
  );
`endif

  assign pick_oh = NCH'(1) << pick_i;

  // Only the granted channel's done counts; done beats the watchdog.
  assign done_s = bus.done[bus.sel];
  assign to_hit = (max_hold != '0) && (hold_cnt == max_hold) && !done_s;
  assign rel    = done_s | to_hit | !enable;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (enable && pick_v) state_n = S_GRANT;
      end
      S_GRANT: begin
        if (rel) begin
          state_n = (guard_cycles == '0) ? S_IDLE : S_GUARD;
        end
      end
      S_GUARD: begin
        if (guard_cnt == GUARD_W'(1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    unique case (state)
      S_GRANT, S_GUARD: bus.busy = 1'b1;
      default:          bus.busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.grant <= '0;
      bus.sel   <= '0;
      ptr       <= IW'(NCH - 1);
      hold_cnt  <= '0;
      guard_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (enable && pick_v) begin
            bus.grant <= pick_oh;
            bus.sel   <= pick_i;
            ptr       <= pick_i;
            hold_cnt  <= HOLD_W'(1);
          end
        end
        S_GRANT: begin
          if (rel) begin
            bus.grant <= '0;
            guard_cnt <= guard_cycles;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_GUARD: begin
          guard_cnt <= guard_cnt - 1'b1;
        end
        default: bus.grant <= '0;
      endcase
    end
  end

  // A new timeout outranks err_clr in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timeout_err <= 1'b0;
      timeout_ch  <= '0;
    end else if (state == S_GRANT && to_hit) begin
      timeout_err <= 1'b1;
      timeout_ch  <= bus.sel;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
      timeout_ch  <= '0;
    end
  end

endmodule

// File: tb/tb_aska_ch_sched.sv
// tb_aska_ch_sched: scoreboard bench for aska_ch_sched; expected grant
// order is queued by each test and checked on every grant rise.
module tb_aska_ch_sched;
  import aska_sched_pkg::*;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       err_clr;
  logic [3:0] guard_cycles;
  logic [7:0] max_hold;
  logic       timeout_err;
  logic [1:0] timeout_ch;
`ifdef ASKA_SCHED_PRIO_EN
  logic [3:0] prio_mask;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int mon_e;
  logic [3:0] prev_g = '0;

  aska_ch_sched_if #(.NCH(NCH)) bus ();

  aska_ch_sched #(.NCH(NCH), .GUARD_W(4), .HOLD_W(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
`ifdef ASKA_SCHED_PRIO_EN
    .prio_mask    (prio_mask),
`endif
    .guard_cycles (guard_cycles),
    .max_hold     (max_hold),
    .err_clr      (err_clr),
    .timeout_err  (timeout_err),
    .timeout_ch   (timeout_ch),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    checks++;
    if (!$onehot0(bus.grant)) begin
      errors++;
      $display("FAIL onehot grant=%b", bus.grant);
    end
    if (bus.grant != '0 && prev_g == '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant grant=%b", bus.grant);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.grant !== 4'(1 << mon_e) || bus.sel !== 2'(mon_e)) begin
          errors++;
          $display("FAIL grant_order got grant=%b sel=%0d want ch%0d",
                   bus.grant, bus.sel, mon_e);
        end
      end
    end
    prev_g = bus.grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int gap);
    gap = 0;
    for (int n = 0; n < 60; n++) begin
      if (bus.grant != '0) return;
      gap++;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL wait_grant no grant within 60 cycles");
  endtask

  task automatic count_high(output int high);
    high = 0;
    for (int n = 0; n < 60; n++) begin
      if (bus.grant == '0) return;
      high++;
      tick();
    end
  endtask

  task automatic test_reset();
    resetn       = 1'b0;
    enable       = 1'b0;
    err_clr      = 1'b0;
    guard_cycles = '0;
    max_hold     = '0;
    bus.req      = '0;
    bus.done     = '0;
`ifdef ASKA_SCHED_PRIO_EN
    prio_mask    = '0;
`endif
    repeat (3) tick();
    checks++;
    if (bus.grant !== 4'b0) begin
      errors++; $display("FAIL rst_grant got %b want 0", bus.grant);
    end
    checks++;
    if (bus.sel !== 2'd0) begin
      errors++; $display("FAIL rst_sel got %0d want 0", bus.sel);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b want 0", bus.busy);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL rst_terr got %b want 0", timeout_err);
    end
    checks++;
    if (timeout_ch !== 2'd0) begin
      errors++; $display("FAIL rst_tch got %0d want 0", timeout_ch);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int gap;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    guard_cycles = 4'd2;
    max_hold     = '0;
    enable       = 1'b1;
    foreach (order[i]) exp_q.push_back(order[i]);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(gap);
      if (k > 0) begin
        checks++;
        if (gap != 3) begin
          errors++; $display("FAIL rr_gap got %0d want 3", gap);
        end
      end
      tick();
      tick();
      bus.done = 4'(1 << order[k]);
      if (k == 4) bus.req = '0;
      tick();
      bus.done = '0;
      if (k == 0) begin
        checks++;
        if (bus.grant !== 4'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL rr_guard got grant=%b busy=%b want 0/1",
                   bus.grant, bus.busy);
        end
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_timeout();
    int gap;
    int high;
    guard_cycles = 4'd2;
    max_hold     = 8'd5;
    exp_q.push_back(2);
    bus.req = 4'b0100;
    wait_grant(gap);
    count_high(high);
    bus.req = '0;
    checks++;
    if (high != 5) begin
      errors++; $display("FAIL to_hold got %0d want 5", high);
    end
    checks++;
    if (timeout_err !== 1'b1 || timeout_ch !== 2'd2) begin
      errors++;
      $display("FAIL to_flag got err=%b ch=%0d want 1/2",
               timeout_err, timeout_ch);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || timeout_ch !== 2'd0) begin
      errors++;
      $display("FAIL to_clr got err=%b ch=%0d want 0/0",
               timeout_err, timeout_ch);
    end

    max_hold = 8'd3;
    exp_q.push_back(2);
    bus.req = 4'b0100;
    wait_grant(gap);
    tick();
    tick();
    bus.done = 4'b0100;
    bus.req  = '0;
    tick();
    bus.done = '0;
    checks++;
    if (bus.grant !== 4'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL done_vs_to got grant=%b err=%b want 0/0",
               bus.grant, timeout_err);
    end

    max_hold = 8'd2;
    err_clr  = 1'b1;
    exp_q.push_back(2);
    bus.req = 4'b0100;
    wait_grant(gap);
    bus.req = '0;
    count_high(high);
    checks++;
    if (high != 2 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL set_vs_clr got hold=%0d err=%b want 2/1",
               high, timeout_err);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL clr_after got %b want 0", timeout_err);
    end
    err_clr  = 1'b0;
    max_hold = '0;
    repeat (3) tick();
  endtask

  task automatic test_enable_abort();
    int gap;
    int high;
    guard_cycles = 4'd1;
    exp_q.push_back(1);
    bus.req = 4'b0010;
    wait_grant(gap);
    tick();
    tick();
    enable = 1'b0;
    tick();
    checks++;
    if (bus.grant !== 4'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_rel got grant=%b err=%b want 0/0",
               bus.grant, timeout_err);
    end
    high = 0;
    repeat (10) begin
      tick();
      if (bus.grant != '0) high++;
    end
    checks++;
    if (high != 0) begin
      errors++; $display("FAIL abort_hold got %0d high want 0", high);
    end
    exp_q.push_back(1);
    enable = 1'b1;
    wait_grant(gap);
    bus.done = 4'b0010;
    bus.req  = '0;
    tick();
    bus.done = '0;
    checks++;
    if (bus.grant !== 4'b0) begin
      errors++; $display("FAIL abort_done got %b want 0", bus.grant);
    end
    repeat (3) tick();
  endtask

  task automatic test_guard_zero();
    int gap;
    int order[4];
    order = '{0, 1, 0, 1};
    guard_cycles = '0;
    foreach (order[i]) exp_q.push_back(order[i]);
    bus.req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      wait_grant(gap);
      if (k > 0) begin
        checks++;
        if (gap != 1) begin
          errors++; $display("FAIL g0_gap got %0d want 1", gap);
        end
      end
      bus.done = 4'(1 << order[k]);
      if (k == 3) bus.req = '0;
      tick();
      bus.done = '0;
    end
    repeat (3) tick();
  endtask

  task automatic test_foreign_done();
    int gap;
    guard_cycles = 4'd1;
    exp_q.push_back(1);
    bus.req = 4'b0010;
    wait_grant(gap);
    bus.done = 4'b1000;
    repeat (3) tick();
    checks++;
    if (bus.grant !== 4'b0010) begin
      errors++; $display("FAIL foreign_done got %b want 0010", bus.grant);
    end
    bus.done = 4'b0010;
    bus.req  = '0;
    tick();
    bus.done = '0;
    checks++;
    if (bus.grant !== 4'b0) begin
      errors++; $display("FAIL own_done got %b want 0", bus.grant);
    end
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    int gap;
    exp_q.push_back(0);
    bus.req = 4'b0001;
    wait_grant(gap);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.grant !== 4'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got grant=%b busy=%b want 0/0",
               bus.grant, bus.busy);
    end
    tick();
    resetn       = 1'b1;
    guard_cycles = '0;
    exp_q.push_back(0);
    bus.req = 4'b1111;
    wait_grant(gap);
    bus.done = 4'b0001;
    bus.req  = '0;
    tick();
    bus.done = '0;
    repeat (3) tick();
  endtask

`ifdef ASKA_SCHED_PRIO_EN
  task automatic test_prio();
    int gap;
    guard_cycles = 4'd1;
    prio_mask    = 4'b1000;
    exp_q.push_back(3);
    exp_q.push_back(3);
    bus.req = 4'b1011;
    wait_grant(gap);
    bus.done = 4'b1000;
    tick();
    bus.done = '0;
    wait_grant(gap);
    bus.done = 4'b1000;
    bus.req  = 4'b0011;
    tick();
    bus.done = '0;
    exp_q.push_back(0);
    wait_grant(gap);
    bus.done = 4'b0001;
    bus.req  = '0;
    tick();
    bus.done = '0;
    repeat (3) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_enable_abort();
    test_guard_zero();
    test_foreign_done();
    test_async_reset();
`ifdef ASKA_SCHED_PRIO_EN
    test_prio();
`endif
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
